regfile_write_arbiter: RTL and testbench

Shares the single register-file write port between two writeback sources: the ALU result path and the memory-load return path. Each source uses a valid/ready handshake. The block registers the winning request onto the register-file write bus (addr/data/enable) one cycle later. It also keeps a per-register pending scoreboard that the issue logic uses to stall on read-after-write hazards.

---
 rtl/regfile_write_arbiter_if.sv | 39 +++
 rtl/regfile_write_arbiter.sv | 87 ++++++++
 tb/tb_regfile_write_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request, scoreboard-mark and register-file write bus shared by
// the register-file write arbiter and its clients.
interface regfile_write_arbiter_if #(
    parameter int unsigned ADDR_BITS = 3,
    parameter int unsigned DATA_BITS = 8
);
    localparam int unsigned NREGS = 1 << ADDR_BITS;

    logic                 alu_valid;
    logic                 alu_ready;
    logic [ADDR_BITS-1:0] alu_addr;
    logic [DATA_BITS-1:0] alu_data;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_data;
    logic                 mark_valid;
    logic [ADDR_BITS-1:0] mark_addr;
    logic                 wr_enable;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic [NREGS-1:0]     pending;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output mark_valid, mark_addr,
        input  alu_ready, mem_ready,
        input  wr_enable, wr_addr, wr_data, pending
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  mark_valid, mark_addr,
        output alu_ready, mem_ready,
        output wr_enable, wr_addr, wr_data, pending
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// and memory-load writeback paths, plus a per-register pending scoreboard.
module regfile_write_arbiter #(
    parameter int unsigned ADDR_BITS = 3,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);
    localparam int unsigned NREGS = 1 << ADDR_BITS;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    src_e                 last_grant;
    src_e                 last_grant_nxt;
    logic                 alu_grant;
    logic                 mem_grant;
    logic                 wr_enable_q;
    logic [ADDR_BITS-1:0] wr_addr_q;
    logic [DATA_BITS-1:0] wr_data_q;
    logic [NREGS-1:0]     pending_q;
    logic [NREGS-1:0]     pending_nxt;

    // Grant selection: a lone requester wins; on contention the source that
    // was not served last wins. Nothing is granted while reset is high.
    always_comb begin
        alu_grant      = 1'b0;
        mem_grant      = 1'b0;
        last_grant_nxt = last_grant;
        if (!reset) begin
            if (bus.alu_valid && (!bus.mem_valid || last_grant == SRC_MEM)) begin
                alu_grant = 1'b1;
            end else if (bus.mem_valid) begin
                mem_grant = 1'b1;
            end
        end
        if (alu_grant) begin
            last_grant_nxt = SRC_ALU;
        end else if (mem_grant) begin
            last_grant_nxt = SRC_MEM;
        end
    end

    // Scoreboard: a new mark beats a completing write to the same register.
    always_comb begin
        pending_nxt = pending_q;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (bus.mark_valid && bus.mark_addr == ADDR_BITS'(i)) begin
                pending_nxt[i] = 1'b1;
            end else if (wr_enable_q && wr_addr_q == ADDR_BITS'(i)) begin
                pending_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= SRC_MEM;
            wr_enable_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            pending_q   <= '0;
        end else begin
            last_grant  <= last_grant_nxt;
            wr_enable_q <= alu_grant | mem_grant;
            pending_q   <= pending_nxt;
            if (alu_grant) begin
                wr_addr_q <= bus.alu_addr;
                wr_data_q <= bus.alu_data;
            end else if (mem_grant) begin
                wr_addr_q <= bus.mem_addr;
                wr_data_q <= bus.mem_data;
            end
        end
    end

    assign bus.alu_ready = alu_grant;
    assign bus.mem_ready = mem_grant;
    assign bus.wr_enable = wr_enable_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.pending   = pending_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized bench for regfile_write_arbiter against a
// cycle-level reference model of grants, write bus and scoreboard.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;

    regfile_write_arbiter_if #(.ADDR_BITS(3), .DATA_BITS(8)) bus ();

    regfile_write_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Stimulus for the next cycle
    logic       rst_v;
    logic       a_v, m_v, k_v;
    logic [2:0] a_a, m_a, k_a;
    logic [7:0] a_d, m_d;

    // Reference model state
    int         m_last;      // 0: ALU was served last, 1: MEM was
    logic       m_we;
    logic [2:0] m_wa;
    logic [7:0] m_wd;
    logic [7:0] m_pend;
    logic       acc_a, acc_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Drive one cycle, check ready mid-cycle, advance model, check registered outputs.
    task automatic step();
        reset          = rst_v;
        bus.alu_valid  = a_v;  bus.alu_addr = a_a; bus.alu_data = a_d;
        bus.mem_valid  = m_v;  bus.mem_addr = m_a; bus.mem_data = m_d;
        bus.mark_valid = k_v;  bus.mark_addr = k_a;
        @(negedge clk);
        if (rst_v) begin
            acc_a = 1'b0; acc_m = 1'b0;
        end else if (a_v && m_v) begin
            acc_a = (m_last == 1);
            acc_m = !acc_a;
        end else begin
            acc_a = a_v; acc_m = m_v;
        end
        check("alu_ready", 32'(bus.alu_ready), 32'(acc_a));
        check("mem_ready", 32'(bus.mem_ready), 32'(acc_m));
        check("ready_excl", 32'(bus.alu_ready & bus.mem_ready), 32'd0);
        if (rst_v) begin
            m_pend = '0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_last = 1;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (k_v && k_a == 3'(i)) m_pend[i] = 1'b1;
                else if (m_we && m_wa == 3'(i)) m_pend[i] = 1'b0;
            end
            if (acc_a) begin
                m_we = 1'b1; m_wa = a_a; m_wd = a_d; m_last = 0;
            end else if (acc_m) begin
                m_we = 1'b1; m_wa = m_a; m_wd = m_d; m_last = 1;
            end else begin
                m_we = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("wr_enable", 32'(bus.wr_enable), 32'(m_we));
        if (m_we || rst_v) begin
            check("wr_addr", 32'(bus.wr_addr), 32'(m_wa));
            check("wr_data", 32'(bus.wr_data), 32'(m_wd));
        end
        check("pending", 32'(bus.pending), 32'(m_pend));
    endtask

    task automatic idle();
        rst_v = 1'b0; a_v = 1'b0; m_v = 1'b0; k_v = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
    endtask

    task automatic drop_accepted();
        if (acc_a) a_v = 1'b0;
        if (acc_m) m_v = 1'b0;
    endtask

    initial begin
        idle();
        a_a = '0; a_d = '0; m_a = '0; m_d = '0; k_a = '0;
        m_last = 1; m_we = 1'b0; m_wa = '0; m_wd = '0; m_pend = '0;
        acc_a = 1'b0; acc_m = 1'b0;
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; bus.mark_valid = 1'b0;
        bus.alu_addr = '0; bus.alu_data = '0; bus.mem_addr = '0; bus.mem_data = '0;
        bus.mark_addr = '0;
        repeat (2) @(posedge clk);
        #1;

        // Single ALU write, one-cycle latency, one-cycle enable pulse
        do_reset();
        a_v = 1'b1; a_a = 3'd3; a_d = 8'h5A;
        step();
        check("t1_wr_data", 32'(bus.wr_data), 32'h5A);
        a_v = 1'b0;
        step();
        check("t1_we_drop", 32'(bus.wr_enable), 32'd0);

        // First contested cycle after reset goes to ALU, then MEM
        do_reset();
        a_v = 1'b1; a_a = 3'd1; a_d = 8'h11;
        m_v = 1'b1; m_a = 3'd2; m_d = 8'h22;
        step();
        check("t2_first_addr", 32'(bus.wr_addr), 32'd1);
        drop_accepted();
        step();
        check("t2_second_addr", 32'(bus.wr_addr), 32'd2);
        drop_accepted();
        step();

        // Continuous contention alternates every cycle
        do_reset();
        for (int i = 0; i < 6; i++) begin
            a_v = 1'b1; m_v = 1'b1;
            a_a = 3'(i); a_d = 8'(8'h30 + i);
            m_a = 3'(7 - i); m_d = 8'(8'hC0 + i);
            step();
            check("t3_alt", 32'(bus.wr_data), (i % 2 == 0) ? 32'(8'h30 + i) : 32'(8'hC0 + i));
        end
        idle();
        step();

        // Scoreboard set, clear, and set-beats-clear
        do_reset();
        k_v = 1'b1; k_a = 3'd5;
        step();
        k_v = 1'b0;
        check("t4_set", 32'(bus.pending), 32'h20);
        m_v = 1'b1; m_a = 3'd5; m_d = 8'h77;
        step();
        m_v = 1'b0;
        step();
        check("t4_clear", 32'(bus.pending), 32'h00);
        k_v = 1'b1; k_a = 3'd5;
        step();
        k_v = 1'b0; m_v = 1'b1; m_a = 3'd5; m_d = 8'h78;
        step();
        m_v = 1'b0; k_v = 1'b1; k_a = 3'd5;
        step();
        k_v = 1'b0;
        check("t4_set_wins", 32'(bus.pending), 32'h20);
        step();

        // Reset discards an in-flight write and restores ALU priority
        a_v = 1'b1; a_a = 3'd4; a_d = 8'h44; k_v = 1'b1; k_a = 3'd2;
        step();
        idle();
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        check("t5_we", 32'(bus.wr_enable), 32'd0);
        check("t5_pend", 32'(bus.pending), 32'd0);
        a_v = 1'b1; a_a = 3'd6; a_d = 8'h66;
        m_v = 1'b1; m_a = 3'd7; m_d = 8'h99;
        step();
        check("t5_alu_first", 32'(bus.wr_data), 32'h66);
        drop_accepted();
        step();
        drop_accepted();

        // MEM streams alone, then ALU arrives and wins the next contest
        for (int i = 0; i < 3; i++) begin
            m_v = 1'b1; m_a = 3'(i); m_d = 8'(8'hA0 + i);
            step();
        end
        a_v = 1'b1; a_a = 3'd3; a_d = 8'h3C;
        m_v = 1'b1; m_a = 3'd4; m_d = 8'hB4;
        step();
        check("t6_alu_wins", 32'(bus.wr_data), 32'h3C);
        drop_accepted();
        step();
        check("t6_mem_held", 32'(bus.wr_data), 32'hB4);
        drop_accepted();
        idle();
        step();

        // Randomized traffic with held requests, marks and occasional reset
        for (int c = 0; c < 400; c++) begin
            rst_v = ($urandom_range(0, 49) == 0);
            if (!a_v) begin
                a_v = ($urandom_range(0, 3) != 0);
                a_a = 3'($urandom); a_d = 8'($urandom);
            end
            if (!m_v) begin
                m_v = ($urandom_range(0, 3) != 0);
                m_a = 3'($urandom); m_d = 8'($urandom);
            end
            k_v = ($urandom_range(0, 2) == 0);
            k_a = 3'($urandom);
            step();
            drop_accepted();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
